// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter over [MIN_VAL, MAX_VAL] with wrap pulses.
// Optional load validation: define BCD_CNT_LOAD_CHECK_EN.
module bcd_mod_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_d0,
  input  logic [3:0] load_d1,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic       carry,
  output logic       borrow,
  output logic       load_err
);

  if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99) begin : g_bad_range
    $error("bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end

  localparam logic [7:0] MIN_BCD = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
  localparam logic [7:0] MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};

  logic [3:0] nxt_d0;
  logic [3:0] nxt_d1;
  logic       nxt_carry;
  logic       nxt_borrow;
  logic       nxt_err;
  logic       cur_ok;

  // Digit-wise BCD compare: valid digits order the same as the packed byte.
  function automatic logic in_range(input logic [3:0] t, input logic [3:0] o);
    return (t <= 4'd9) && (o <= 4'd9) &&
           ({t, o} >= MIN_BCD) && ({t, o} <= MAX_BCD);
  endfunction

  assign cur_ok = in_range(d1, d0);

  // Next state: load beats enable; an illegal state recovers to an endpoint.
  always_comb begin
    nxt_d0     = d0;
    nxt_d1     = d1;
    nxt_carry  = 1'b0;
    nxt_borrow = 1'b0;
    nxt_err    = 1'b0;
    if (load) begin
`ifdef BCD_CNT_LOAD_CHECK_EN
      if (in_range(load_d1, load_d0)) begin
        nxt_d0 = load_d0;
        nxt_d1 = load_d1;
      end else begin
        nxt_err = 1'b1;
      end
`else
      nxt_d0 = load_d0;
      nxt_d1 = load_d1;
`endif
    end else if (enable) begin
      if (!cur_ok) begin
        if (up) begin
          {nxt_d1, nxt_d0} = MIN_BCD;
          nxt_carry        = 1'b1;
        end else begin
          {nxt_d1, nxt_d0} = MAX_BCD;
        end
      end else if (up) begin
        if ({d1, d0} == MAX_BCD) begin
          {nxt_d1, nxt_d0} = MIN_BCD;
          nxt_carry        = 1'b1;
        end else if (d0 == 4'd9) begin
          nxt_d0 = 4'd0;
          nxt_d1 = d1 + 4'd1;
        end else begin
          nxt_d0 = d0 + 4'd1;
        end
      end else begin
        if ({d1, d0} == MIN_BCD) begin
          {nxt_d1, nxt_d0} = MAX_BCD;
          nxt_borrow       = 1'b1;
        end else if (d0 == 4'd0) begin
          nxt_d0 = 4'd9;
          nxt_d1 = d1 - 4'd1;
        end else begin
          nxt_d0 = d0 - 4'd1;
        end
      end
    end
  end

  // State and pulse registers; reset forces MIN_VAL at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d0       <= MIN_BCD[3:0];
      d1       <= MIN_BCD[7:4];
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      d0       <= nxt_d0;
      d1       <= nxt_d1;
      carry    <= nxt_carry;
      borrow   <= nxt_borrow;
      load_err <= nxt_err;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter over four parameter sets.
// Load-check expectations follow BCD_CNT_LOAD_CHECK_EN.
module tb_bcd_mod_counter;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
    logic       c;
    logic       b;
    logic       e;
  } obs_t;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] l1;
    logic [3:0] l0;
    obs_t       ex;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic up = 1'b0;
  logic load = 1'b0;
  logic [3:0] load_d0 = 4'd0;
  logic [3:0] load_d1 = 4'd0;

  logic [3:0] a_d0, a_d1, b_d0, b_d1, c_d0, c_d1, e_d0, e_d1;
  logic a_c, a_b, a_e, b_c, b_b, b_e, c_c, c_b, c_e, e_c, e_b, e_e;

  obs_t o [4];
  obs_t exp_q [$];
  step_t s [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_d0(load_d0), .load_d1(load_d1), .d0(a_d0), .d1(a_d1),
    .carry(a_c), .borrow(a_b), .load_err(a_e));

  bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_d0(load_d0), .load_d1(load_d1), .d0(b_d0), .d1(b_d1),
    .carry(b_c), .borrow(b_b), .load_err(b_e));

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(23)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_d0(load_d0), .load_d1(load_d1), .d0(c_d0), .d1(c_d1),
    .carry(c_c), .borrow(c_b), .load_err(c_e));

  bcd_mod_counter #(.MIN_VAL(5), .MAX_VAL(59)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_d0(load_d0), .load_d1(load_d1), .d0(e_d0), .d1(e_d1),
    .carry(e_c), .borrow(e_b), .load_err(e_e));

  assign o[0] = {a_d1, a_d0, a_c, a_b, a_e};
  assign o[1] = {b_d1, b_d0, b_c, b_b, b_e};
  assign o[2] = {c_d1, c_d0, c_c, c_b, c_e};
  assign o[3] = {e_d1, e_d0, e_c, e_b, e_e};

  function automatic obs_t mk(input int v, input logic c,
                              input logic b, input logic e);
    obs_t r;
    r.d1 = 4'(v / 10);
    r.d0 = 4'(v % 10);
    r.c  = c;
    r.b  = b;
    r.e  = e;
    return r;
  endfunction

  function automatic step_t st(input logic en_i, input logic up_i,
                               input logic ld_i, input logic [3:0] l1_i,
                               input logic [3:0] l0_i, input obs_t ex_i);
    step_t r;
    r.en = en_i;
    r.up = up_i;
    r.ld = ld_i;
    r.l1 = l1_i;
    r.l0 = l0_i;
    r.ex = ex_i;
    return r;
  endfunction

  task automatic drive(input step_t x);
    enable  = x.en;
    up      = x.up;
    load    = x.ld;
    load_d1 = x.l1;
    load_d0 = x.l0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    enable = 1'b0;
    load   = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t rv [4];
    rv = '{mk(0, 0, 0, 0), mk(1, 0, 0, 0), mk(0, 0, 0, 0), mk(5, 0, 0, 0)};
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o[k] !== rv[k]) begin
        errors++;
        $display("FAIL reset u%0d: got %h want %h", k, o[k], rv[k]);
      end
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    obs_t got, ex;
    int v = 0;
    pulse_reset();
    s = {};
    for (int i = 0; i < 60; i++) begin
      s.push_back(st(1, 1, 0, 0, 0, mk((v + 1) % 60, v == 59, 0, 0)));
      v = (v + 1) % 60;
    end
    s.push_back(st(0, 1, 0, 0, 0, mk(0, 0, 0, 0)));
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[0];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL count_up step %0d: got %h want %h", i, got, ex);
      end
    end
  endtask

  task automatic test_borrow();
    obs_t got, ex;
    pulse_reset();
    s = {};
    s.push_back(st(0, 0, 1, 4'd0, 4'd1, mk(1, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(12, 0, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, mk(12, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(11, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(12, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(1, 1, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(12, 0, 1, 0)));
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[1];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL borrow step %0d: got %h want %h", i, got, ex);
      end
    end
  endtask

  task automatic test_load_priority();
    obs_t got, ex;
    pulse_reset();
    s = {};
    s.push_back(st(1, 1, 1, 4'd2, 4'd3, mk(23, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(0, 1, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(23, 0, 1, 0)));
    s.push_back(st(1, 0, 1, 4'd1, 4'd0, mk(10, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(9, 0, 0, 0)));
    s.push_back(st(0, 1, 0, 0, 0, mk(9, 0, 0, 0)));
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[2];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL load_priority step %0d: got %h want %h", i, got, ex);
      end
    end
  endtask

  task automatic test_load_check();
    obs_t got, ex;
    obs_t raw0a;
    raw0a = {4'd0, 4'hA, 1'b0, 1'b0, 1'b0};
    pulse_reset();
    s = {};
`ifdef BCD_CNT_LOAD_CHECK_EN
    s.push_back(st(0, 1, 1, 4'd6, 4'd0, mk(0, 0, 0, 1)));
    s.push_back(st(0, 1, 0, 0, 0, mk(0, 0, 0, 0)));
    s.push_back(st(1, 1, 1, 4'd0, 4'hA, mk(0, 0, 0, 1)));
    s.push_back(st(1, 1, 1, 4'd4, 4'd5, mk(45, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(46, 0, 0, 0)));
`else
    s.push_back(st(0, 1, 1, 4'd6, 4'd0, mk(60, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(0, 1, 0, 0)));
    s.push_back(st(0, 0, 1, 4'd6, 4'd0, mk(60, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(59, 0, 0, 0)));
    s.push_back(st(0, 1, 1, 4'd0, 4'hA, raw0a));
    s.push_back(st(1, 1, 0, 0, 0, mk(0, 1, 0, 0)));
    s.push_back(st(0, 1, 0, 0, 0, mk(0, 0, 0, 0)));
`endif
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[0];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL load_check step %0d: got %h want %h", i, got, ex);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, ex;
    pulse_reset();
    s = {};
    s.push_back(st(0, 1, 1, 4'd5, 4'd9, mk(59, 0, 0, 0)));
    s.push_back(st(1, 1, 0, 0, 0, mk(5, 1, 0, 0)));
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[3];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL async_pre step %0d: got %h want %h", i, got, ex);
      end
    end
    enable = 1'b0;
    exp_q.push_back(mk(5, 0, 0, 0));
    reset = 1'b1;
    #1;
    got = o[3];
    ex = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL async_clear: got %h want %h", got, ex);
    end
    #1;
    reset = 1'b0;
    s = {};
    s.push_back(st(1, 1, 0, 0, 0, mk(6, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(5, 0, 0, 0)));
    s.push_back(st(1, 0, 0, 0, 0, mk(59, 0, 1, 0)));
    foreach (s[i]) begin
      exp_q.push_back(s[i].ex);
      drive(s[i]);
      got = o[3];
      ex = exp_q.pop_front();
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL async_post step %0d: got %h want %h", i, got, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_borrow();
    test_load_priority();
    test_load_check();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
